// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter and sequencer in front of a single-port data memory.
// Port 0 is the CPU load/store stage, port 1 is the loader/debug master.
// One request is accepted at a time. The arbiter drives a single MEM strobe
// for WAIT_CYCLES cycles and then returns a one-cycle response pulse to the
// port that won. MEM_READ and MEM_WRITE are never high together.
//
// Handshake: a requester raises REQn_VALID and holds it, together with its
// WE/ADDR/WDATA fields, until it sees REQn_READY. The request is accepted on
// the rising edge where VALID and READY are both high. READY is combinational
// and high only in IDLE, for the single port chosen by the grant logic.
// Responses have no backpressure: RSPn_VALID is a one-cycle pulse, with
// RSPn_RDATA and RSPn_ERR valid only while it is high.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins if both ports are
//                          valid (port 1 can starve). When undefined, the
//                          ports are served round-robin.
//
// Ports:
//   CLK, RST_N              clock (rising edge), synchronous active-low reset
//   REQn_VALID/WE/ADDR/WDATA request from port n
//   REQn_READY              request accepted on this edge when VALID & READY
//   RSPn_VALID/RDATA/ERR    registered response pulse to port n
//   MEM_READ/MEM_WRITE      memory strobes, high only in ACCESS
//   MEM_ADRESS/MEM_WRITE_DATA memory address and write data (held when idle)
//   MEM_READ_DATA           memory read data
//   DBG_STATE               current FSM state (0 IDLE, 1 ACCESS, 2 RESPOND)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0_VALID,
  input  logic              REQ0_WE,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_WDATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic              REQ1_WE,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_WDATA,
  output logic              REQ1_READY,
  output logic              RSP0_VALID,
  output logic [DATA_W-1:0] RSP0_RDATA,
  output logic              RSP0_ERR,
  output logic              RSP1_VALID,
  output logic [DATA_W-1:0] RSP1_RDATA,
  output logic              RSP1_ERR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADRESS,
  output logic [DATA_W-1:0] MEM_WRITE_DATA,
  input  logic [DATA_W-1:0] MEM_READ_DATA,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_e;

  // Counter value on the final ACCESS cycle.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e              state_q;
  logic                last_grant_q;
  logic                port_q;
  logic                we_q;
  logic [3:0]          cnt_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp0_valid_q;
  logic [DATA_W-1:0]   rsp0_rdata_q;
  logic                rsp0_err_q;
  logic                rsp1_valid_q;
  logic [DATA_W-1:0]   rsp1_rdata_q;
  logic                rsp1_err_q;

  // Grant selection, only meaningful while grant_any is high.
  logic                grant_any;
  logic                grant_port;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_in_range;

  always_comb begin
    grant_any  = REQ0_VALID | REQ1_VALID;
    grant_port = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_port = 1'b0;
`else
      grant_port = ~last_grant_q;
`endif
    end else if (REQ1_VALID) begin
      grant_port = 1'b1;
    end
  end

  assign REQ0_READY   = (state_q == S_IDLE) && grant_any && !grant_port;
  assign REQ1_READY   = (state_q == S_IDLE) && grant_any &&  grant_port;
  assign accept       = REQ0_READY | REQ1_READY;

  assign sel_we       = grant_port ? REQ1_WE    : REQ0_WE;
  assign sel_addr     = grant_port ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_wdata    = grant_port ? REQ1_WDATA : REQ0_WDATA;
  assign sel_in_range = sel_addr < ADDR_W'(MEM_DEPTH);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_grant_q <= grant_port;
            port_q       <= grant_port;
            we_q         <= sel_we;
            cnt_q        <= 4'd0;
            if (sel_in_range) begin
              // Only in-range requests touch the memory-facing registers,
              // so the MEM bus never moves for a rejected address.
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              mem_read_q  <= !sel_we;
              mem_write_q <= sel_we;
              state_q     <= S_ACCESS;
            end else begin
              if (grant_port) begin
                rsp1_valid_q <= 1'b1;
                rsp1_rdata_q <= '0;
                rsp1_err_q   <= 1'b1;
              end else begin
                rsp0_valid_q <= 1'b1;
                rsp0_rdata_q <= '0;
                rsp0_err_q   <= 1'b1;
              end
              state_q <= S_RESPOND;
            end
          end
        end

        S_ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (port_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= we_q ? '0 : MEM_READ_DATA;
              rsp1_err_q   <= 1'b0;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= we_q ? '0 : MEM_READ_DATA;
              rsp0_err_q   <= 1'b0;
            end
            state_q <= S_RESPOND;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_RESPOND: begin
          // Response fields return to 0 with the pulse.
          rsp0_valid_q <= 1'b0;
          rsp0_rdata_q <= '0;
          rsp0_err_q   <= 1'b0;
          rsp1_valid_q <= 1'b0;
          rsp1_rdata_q <= '0;
          rsp1_err_q   <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign MEM_READ       = mem_read_q;
  assign MEM_WRITE      = mem_write_q;
  assign MEM_ADRESS     = mem_addr_q;
  assign MEM_WRITE_DATA = mem_wdata_q;
  assign RSP0_VALID     = rsp0_valid_q;
  assign RSP0_RDATA     = rsp0_rdata_q;
  assign RSP0_ERR       = rsp0_err_q;
  assign RSP1_VALID     = rsp1_valid_q;
  assign RSP1_RDATA     = rsp1_rdata_q;
  assign RSP1_ERR       = rsp1_err_q;
  assign DBG_STATE      = state_q;

endmodule
